if_fetch_ctrl: RTL

Instruction-fetch controller that consumes the PC register output and drives the PC register's advance enable. It issues one instruction-memory request per PC over a valid/ready request channel and accepts the matching response. It presents registered pc/instruction/fault to the IF/ID boundary, and handles downstream stall, branch flush and fetch faults. It sits between the PC register, instruction memory and the decode stage.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_skid_buf.sv | 53 +++++
 rtl/if_fetch_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared constants and state encodings for the instruction
//               fetch controller.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int          c_XLEN      = 32;
    localparam logic [31:0] c_NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

    // Fetch FSM state encodings
    localparam int         c_STATE_W = 3;
    localparam logic [2:0] S_REQ     = 3'd0;  // ready to issue a request
    localparam logic [2:0] S_WAIT    = 3'd1;  // request accepted, awaiting response
    localparam logic [2:0] S_HOLD    = 3'd2;  // response parked while decode stalls
    localparam logic [2:0] S_DROP    = 3'd3;  // discard the response of a flushed fetch
    localparam logic [2:0] S_FAULT   = 3'd4;  // fetch fault taken, wait for redirect

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : fetch_skid_buf
// Description : Single-entry hold buffer for a fetch response (pc, raw
//               instruction and bus error) captured while decode is stalled.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_skid_buf #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            i_reset_n,
    input  logic            i_load,
    input  logic            i_clear,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_instr,
    input  logic            i_err,
    output logic            o_valid,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_instr,
    output logic            o_err
);

    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_instr;
    logic            r_err;

    // Capture on load, empty on clear; clear wins so a flush can never leave a stale entry.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_instr <= '0;
            r_err   <= 1'b0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_pc    <= i_pc;
            r_instr <= i_instr;
            r_err   <= i_err;
        end
    end

    assign o_valid = r_valid;
    assign o_pc    = r_pc;
    assign o_instr = r_instr;
    assign o_err   = r_err;

endmodule : fetch_skid_buf
`default_nettype wire

// File: rtl/if_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_ctrl
// Description : Instruction fetch controller. Issues one instruction-memory
//               request per PC, advances the PC register on acceptance or
//               redirect, and presents a registered pc/instr/fault entry to
//               the IF/ID boundary with stall, flush and fault handling.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int              XLEN      = c_XLEN,
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(c_NOP_INSTR)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_in,
    output logic            pc_en,
    input  logic            flush,
    input  logic            id_stall,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            imem_rsp_err,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr,
    output logic            if_fault
);

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_state_nxt;
    logic [XLEN-1:0]      r_req_pc;

    logic                 r_if_valid;
    logic [XLEN-1:0]      r_if_pc;
    logic [XLEN-1:0]      r_if_instr;
    logic                 r_if_fault;

    logic                 w_misaligned;
    logic                 w_handshake;
    logic                 w_if_load;
    logic [XLEN-1:0]      w_if_pc_d;
    logic [XLEN-1:0]      w_if_instr_d;
    logic                 w_if_fault_d;
    logic                 w_buf_load;
    logic                 w_buf_clear;
    logic                 w_buf_valid;
    logic [XLEN-1:0]      w_buf_pc;
    logic [XLEN-1:0]      w_buf_instr;
    logic                 w_buf_err;

    // Requests only go out for word-aligned PCs; reset gating keeps the bus quiet during reset.
    assign w_misaligned   = (pc_in[1:0] != 2'b00);
    assign imem_req_valid = reset && (r_state == S_REQ) && !flush && !w_misaligned;
    assign imem_req_addr  = pc_in;
    assign w_handshake    = imem_req_valid && imem_req_ready;
    assign pc_en          = w_handshake || (reset && flush);

    // State register and the PC of the single outstanding request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_REQ;
            r_req_pc <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_handshake) begin
                r_req_pc <= pc_in;
            end
        end
    end

    // Next-state, IF/ID load selection and hold-buffer control; flush dominates every state.
    always_comb begin
        w_state_nxt  = r_state;
        w_if_load    = 1'b0;
        w_if_pc_d    = r_req_pc;
        w_if_instr_d = NOP_INSTR;
        w_if_fault_d = 1'b0;
        w_buf_load   = 1'b0;
        w_buf_clear  = 1'b0;
        case (r_state)
            S_REQ: begin
                if (!flush) begin
                    if (w_handshake) begin
                        w_state_nxt = S_WAIT;
                    end else if (w_misaligned && !id_stall) begin
                        w_if_load    = 1'b1;
                        w_if_pc_d    = pc_in;
                        w_if_fault_d = 1'b1;
                        w_state_nxt  = S_FAULT;
                    end
                end
            end
            S_WAIT: begin
                if (flush) begin
                    // A response landing with the flush is the stale one; nothing left to drop.
                    w_state_nxt = imem_rsp_valid ? S_REQ : S_DROP;
                end else if (imem_rsp_valid) begin
                    if (id_stall) begin
                        w_buf_load  = 1'b1;
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_if_load    = 1'b1;
                        w_if_instr_d = imem_rsp_err ? NOP_INSTR : imem_rsp_data;
                        w_if_fault_d = imem_rsp_err;
                        w_state_nxt  = imem_rsp_err ? S_FAULT : S_REQ;
                    end
                end
            end
            S_HOLD: begin
                if (flush) begin
                    w_buf_clear = 1'b1;
                    w_state_nxt = S_REQ;
                end else if (!id_stall && w_buf_valid) begin
                    w_if_load    = 1'b1;
                    w_if_pc_d    = w_buf_pc;
                    w_if_instr_d = w_buf_err ? NOP_INSTR : w_buf_instr;
                    w_if_fault_d = w_buf_err;
                    w_buf_clear  = 1'b1;
                    w_state_nxt  = w_buf_err ? S_FAULT : S_REQ;
                end
            end
            S_DROP: begin
                // The discarded response retires the only outstanding request, even under
                // a further flush, so the FSM cannot wait forever for a second response.
                if (imem_rsp_valid) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_FAULT: begin
                if (flush) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: begin
                w_state_nxt = S_REQ;
            end
        endcase
    end

    // IF/ID boundary: flush kills, stall holds, otherwise load an entry or insert a bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_if_valid <= 1'b0;
            r_if_pc    <= '0;
            r_if_instr <= NOP_INSTR;
            r_if_fault <= 1'b0;
        end else if (flush) begin
            r_if_valid <= 1'b0;
            r_if_instr <= NOP_INSTR;
            r_if_fault <= 1'b0;
        end else if (w_if_load) begin
            r_if_valid <= 1'b1;
            r_if_pc    <= w_if_pc_d;
            r_if_instr <= w_if_instr_d;
            r_if_fault <= w_if_fault_d;
        end else if (!id_stall) begin
            r_if_valid <= 1'b0;
            r_if_instr <= NOP_INSTR;
            r_if_fault <= 1'b0;
        end
    end

    fetch_skid_buf #(
        .XLEN (XLEN)
    ) u_skid_buf (
        .clk       (clk),
        .i_reset_n (reset),
        .i_load    (w_buf_load),
        .i_clear   (w_buf_clear),
        .i_pc      (r_req_pc),
        .i_instr   (imem_rsp_data),
        .i_err     (imem_rsp_err),
        .o_valid   (w_buf_valid),
        .o_pc      (w_buf_pc),
        .o_instr   (w_buf_instr),
        .o_err     (w_buf_err)
    );

    assign if_valid = r_if_valid;
    assign if_pc    = r_if_pc;
    assign if_instr = r_if_instr;
    assign if_fault = r_if_fault;

endmodule : if_fetch_ctrl
`default_nettype wire
